nibble_serial_sub32: RTL

Multi-cycle, nibble-serial subtractor. It computes `operA - operB - Bin` for 32-bit operands, one 4-bit digit per clock, and propagates the borrow between digits through a register. It is the subtraction counterpart to the team's combinational 32-bit adders and sits in the datapath where area matters more than latency. Valid/ready handshakes on both sides let it stall against slow producers and consumers.

---
 rtl/nibble_serial_sub32.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_sub32.sv
// nibble_serial_sub32: multi-cycle subtractor computing operA - operB - Bin
// one DIGIT-bit digit per clock, borrow carried between digits in a register.
// Subtraction is done as A + ~B + ~Bin, so the internal carry is the inverted
// borrow. Valid/ready handshakes on both the operand and the result side.
module nibble_serial_sub32 #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operA,
    input  logic [WIDTH-1:0] operB,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultOUT,
    output logic             Bout,
    output logic             ovf,
    output logic             zero
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Captured operands: minuend as-is, subtrahend pre-inverted
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_bn;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    // Result and flag registers, held until overwritten by the next operation
    logic [WIDTH-1:0] r_result;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last_step;
    logic [31:0]      w_base;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_bn_dig;
    logic [DIGIT:0]   w_sum;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_a_msb;
    logic             w_b_msb;
    logic             w_ovf_nxt;
    logic             w_bout_nxt;
    logic             w_zero_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; handshake outputs come straight from the state register
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST_STEP) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_last_step = (r_state == RUN) && (r_cnt == LAST_STEP);

    // Digit select and per-digit add of A, ~B and the running carry
    assign w_base   = 32'(r_cnt) * 32'(DIGIT);
    assign w_a_dig  = r_a[w_base +: DIGIT];
    assign w_bn_dig = r_bn[w_base +: DIGIT];
    assign w_sum    = {1'b0, w_a_dig} + {1'b0, w_bn_dig} + {{DIGIT{1'b0}}, r_carry};

    // Result with the current digit merged in
    always_comb begin
        w_result_nxt = r_result;
        w_result_nxt[w_base +: DIGIT] = w_sum[DIGIT-1:0];
    end

    // Flags are evaluated on the final digit so they are ready with out_valid
    assign w_a_msb    = r_a[WIDTH-1];
    assign w_b_msb    = ~r_bn[WIDTH-1];
    assign w_bout_nxt = ~w_sum[DIGIT];
    assign w_ovf_nxt  = (w_a_msb != w_b_msb) && (w_result_nxt[WIDTH-1] != w_a_msb);
    assign w_zero_nxt = ~|w_result_nxt;

    // Operand capture, digit stepping and carry propagation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_bn     <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a     <= operA;
            r_bn    <= ~operB;
            r_carry <= ~Bin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_result <= w_result_nxt;
            r_carry  <= w_sum[DIGIT];
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Status flags, updated once per operation on the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_last_step) begin
            r_bout <= w_bout_nxt;
            r_ovf  <= w_ovf_nxt;
            r_zero <= w_zero_nxt;
        end
    end

    assign resultOUT = r_result;
    assign Bout      = r_bout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
